// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmitter bus: command handshake plus open-drain pin view/enables.
`timescale 1ns/1ps
interface ps2_host_tx_if;
  logic       key_clk;
  logic       key_din;
  logic       key_clk_oe;
  logic       key_dout_oe;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_valid, tx_data, key_clk, key_din,
    input  tx_busy, tx_done, tx_err, key_clk_oe, key_dout_oe
  );

  modport slave (
    input  tx_valid, tx_data, key_clk, key_din,
    output tx_busy, tx_done, tx_err, key_clk_oe, key_dout_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain pull-low enables.
// Optional automatic retry (3 attempts total) when PS2_TX_RESEND_EN is defined.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000
) (
  input  logic         clk,
  input  logic         rst_n,
  ps2_host_tx_if.slave bus
);
  localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, ACK, WAITIDLE, DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic          dout_q, dout_d;
  logic          err_q, err_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic [1:0]    clk_sync_q, din_sync_q;
  logic          clk_prev_q;
  logic          clk_s, din_s, fall, retry_ok;

  assign clk_s = clk_sync_q[1];
  assign din_s = din_sync_q[1];
  assign fall  = clk_prev_q & ~clk_s & ((state_q == DATA) | (state_q == ACK));

`ifdef PS2_TX_RESEND_EN
  logic [1:0] retry_q, retry_d;
  assign retry_ok = (retry_q != 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retry_q <= '0;
    else        retry_q <= retry_d;
  end
`else
  assign retry_ok = 1'b0;
`endif

  // Idle lines read high, so synchronizers reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      din_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], bus.key_clk};
      din_sync_q <= {din_sync_q[0], bus.key_din};
      clk_prev_q <= clk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      parity_q  <= 1'b0;
      dout_q    <= 1'b0;
      err_q     <= 1'b0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      dout_q    <= dout_d;
      err_q     <= err_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    data_d          = data_q;
    parity_d        = parity_q;
    dout_d          = dout_q;
    err_d           = err_q;
    bit_cnt_d       = bit_cnt_q;
    inh_cnt_d       = inh_cnt_q;
    wd_cnt_d        = wd_cnt_q;
`ifdef PS2_TX_RESEND_EN
    retry_d         = retry_q;
`endif
    bus.key_clk_oe  = 1'b0;
    bus.key_dout_oe = 1'b0;
    bus.tx_done     = 1'b0;
    bus.tx_err      = 1'b0;
    bus.tx_busy     = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.tx_valid) begin
          data_d    = bus.tx_data;
          parity_d  = ~^bus.tx_data;
          err_d     = 1'b0;
          inh_cnt_d = '0;
`ifdef PS2_TX_RESEND_EN
          retry_d   = '0;
`endif
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        bus.key_clk_oe = 1'b1;
        inh_cnt_d      = inh_cnt_q + 1'b1;
        if (inh_cnt_q == INH_LAST) begin
          bus.key_dout_oe = 1'b1;
          state_d         = RTS;
        end
      end
      RTS: begin
        bus.key_dout_oe = 1'b1;
        bit_cnt_d       = '0;
        wd_cnt_d        = '0;
        dout_d          = 1'b1;
        state_d         = DATA;
      end
      DATA: begin
        bus.key_dout_oe = dout_q;
        wd_cnt_d        = wd_cnt_q + 1'b1;
        if (wd_cnt_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (fall) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q < 4'd8) begin
            dout_d = ~data_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            dout_d = ~parity_q;
          end else begin
            dout_d  = 1'b0;
            state_d = ACK;
          end
        end
      end
      ACK: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        if (wd_cnt_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (fall) begin
          err_d   = din_s;
          state_d = WAITIDLE;
        end
      end
      WAITIDLE: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        if (wd_cnt_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (clk_s && din_s) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.tx_done = ~err_q;
        bus.tx_err  = err_q & ~retry_ok;
        // Timeouts also land here, so one retry path serves both failure kinds.
        if (err_q && retry_ok) begin
`ifdef PS2_TX_RESEND_EN
          retry_d   = retry_q + 2'd1;
`endif
          err_d     = 1'b0;
          inh_cnt_d = '0;
          state_d   = INHIBIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
